// File: rtl/memory_port_arbiter.sv
// Two-port (core/loader) arbiter in front of a single ROM/RAM memory unit.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default build uses fixed core priority.
module memory_port_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  c_req,
  input  logic                  c_we,
  input  logic                  c_sel,
  input  logic [ADDR_WIDTH-1:0] c_addr,
  input  logic [DATA_WIDTH-1:0] c_wdata,
  output logic                  c_gnt,
  output logic                  c_rvalid,
  input  logic                  l_req,
  input  logic                  l_we,
  input  logic                  l_sel,
  input  logic [ADDR_WIDTH-1:0] l_addr,
  input  logic [DATA_WIDTH-1:0] l_wdata,
  output logic                  l_gnt,
  output logic                  l_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_sel,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic                  rom_wr_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  owner_q, owner_d;   // 0 = core, 1 = loader
  logic                  we_q, we_d;
  logic                  c_gnt_q, c_gnt_d;
  logic                  l_gnt_q, l_gnt_d;
  logic                  c_rvalid_q, c_rvalid_d;
  logic                  l_rvalid_q, l_rvalid_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic                  mem_sel_q, mem_sel_d;
  logic                  rom_wr_err_q, rom_wr_err_d;

  logic                  pick_l;
  logic                  win_we;
  logic                  win_sel;
  logic [ADDR_WIDTH-1:0] win_addr;
  logic [DATA_WIDTH-1:0] win_wdata;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q, last_d;    // 1 = loader owned the previous access

  assign pick_l = l_req & (~c_req | ~last_q);
`else
  assign pick_l = l_req & ~c_req;
`endif

  assign win_we    = pick_l ? l_we    : c_we;
  assign win_sel   = pick_l ? l_sel   : c_sel;
  assign win_addr  = pick_l ? l_addr  : c_addr;
  assign win_wdata = pick_l ? l_wdata : c_wdata;

  // Next-state and next-output logic; memory-side outputs are the latched request
  // fields, registered so they are only non-zero while in ISSUE.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    c_gnt_d      = 1'b0;
    l_gnt_d      = 1'b0;
    c_rvalid_d   = 1'b0;
    l_rvalid_d   = 1'b0;
    mem_addr_d   = {ADDR_WIDTH{1'b0}};
    mem_wdata_d  = {DATA_WIDTH{1'b0}};
    mem_we_d     = 1'b0;
    mem_sel_d    = 1'b0;
    rom_wr_err_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_d       = last_q;
`endif
    case (state_q)
      IDLE, RESP: begin
        if (c_req | l_req) begin
          state_d      = ISSUE;
          owner_d      = pick_l;
          we_d         = win_we;
          c_gnt_d      = ~pick_l;
          l_gnt_d      = pick_l;
          mem_addr_d   = win_addr;
          mem_wdata_d  = win_wdata;
          mem_sel_d    = win_sel;
          mem_we_d     = win_we & win_sel;
          rom_wr_err_d = win_we & ~win_sel;
`ifdef ARB_ROUND_ROBIN_EN
          last_d       = pick_l;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        state_d    = RESP;
        c_rvalid_d = ~we_q & ~owner_q;
        l_rvalid_d = ~we_q & owner_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched fields and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      we_q         <= 1'b0;
      c_gnt_q      <= 1'b0;
      l_gnt_q      <= 1'b0;
      c_rvalid_q   <= 1'b0;
      l_rvalid_q   <= 1'b0;
      mem_addr_q   <= {ADDR_WIDTH{1'b0}};
      mem_wdata_q  <= {DATA_WIDTH{1'b0}};
      mem_we_q     <= 1'b0;
      mem_sel_q    <= 1'b0;
      rom_wr_err_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_q       <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      c_gnt_q      <= c_gnt_d;
      l_gnt_q      <= l_gnt_d;
      c_rvalid_q   <= c_rvalid_d;
      l_rvalid_q   <= l_rvalid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      mem_sel_q    <= mem_sel_d;
      rom_wr_err_q <= rom_wr_err_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_q       <= last_d;
`endif
    end
  end

  assign c_gnt      = c_gnt_q;
  assign l_gnt      = l_gnt_q;
  assign c_rvalid   = c_rvalid_q;
  assign l_rvalid   = l_rvalid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign mem_sel    = mem_sel_q;
  assign rom_wr_err = rom_wr_err_q;
  // Memory read data is passed straight through during the read response only.
  assign rdata      = (c_rvalid_q | l_rvalid_q) ? mem_q : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter; expectations follow ARB_ROUND_ROBIN_EN when defined.
// The memory model returns (registered address XOR 0x5A5A5A5A) one clock after the address.
module tb_memory_port_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_req, c_we, c_sel, l_req, l_we, l_sel;
  logic [AW-1:0] c_addr, l_addr;
  logic [DW-1:0] c_wdata, l_wdata;
  logic          c_gnt, c_rvalid, l_gnt, l_rvalid;
  logic [DW-1:0] rdata, mem_wdata, mem_q;
  logic [AW-1:0] mem_addr;
  logic          mem_we, mem_sel, rom_wr_err;
  logic [6:0]    flags;
  int            checks = 0;
  int            errors = 0;

  memory_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_sel(c_sel), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid),
    .l_req(l_req), .l_we(l_we), .l_sel(l_sel), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_sel(mem_sel), .mem_q(mem_q), .rom_wr_err(rom_wr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_q <= mem_addr ^ 32'h5A5A_5A5A;

  // {c_gnt, l_gnt, c_rvalid, l_rvalid, mem_we, mem_sel, rom_wr_err}
  assign flags = {c_gnt, l_gnt, c_rvalid, l_rvalid, mem_we, mem_sel, rom_wr_err};

  task automatic clear_inputs();
    c_req = 1'b0; c_we = 1'b0; c_sel = 1'b0; c_addr = 32'h0; c_wdata = 32'h0;
    l_req = 1'b0; l_we = 1'b0; l_sel = 1'b0; l_addr = 32'h0; l_wdata = 32'h0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (flags !== 7'b0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: flags=%b addr=%h wdata=%h rdata=%h, required all 0",
               flags, mem_addr, mem_wdata, rdata);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_core_read();
    c_req = 1'b1; c_we = 1'b0; c_sel = 1'b1; c_addr = 32'h1001_0004;
    @(negedge clk);
    checks++;
    if (flags !== 7'b1000010 || mem_addr !== 32'h1001_0004) begin
      errors++;
      $display("FAIL core_read_issue: flags=%b addr=%h, required 1000010 10010004", flags, mem_addr);
    end
    c_req = 1'b0;
    @(negedge clk);
    checks++;
    if (flags !== 7'b0010000 || rdata !== 32'h4A5B_5A5E || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL core_read_resp: flags=%b rdata=%h addr=%h, required 0010000 4a5b5a5e 0",
               flags, rdata, mem_addr);
    end
    @(negedge clk);
    checks++;
    if (flags !== 7'b0 || rdata !== 32'h0) begin
      errors++;
      $display("FAIL core_read_idle: flags=%b rdata=%h, required 0 0", flags, rdata);
    end
  endtask

  task automatic test_loader_write();
    l_req = 1'b1; l_we = 1'b1; l_sel = 1'b1; l_addr = 32'h0040_0000; l_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    checks++;
    if (flags !== 7'b0100110 || mem_addr !== 32'h0040_0000 || mem_wdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL loader_write_issue: flags=%b addr=%h wdata=%h, required 0100110 00400000 deadbeef",
               flags, mem_addr, mem_wdata);
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if (flags !== 7'b0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL loader_write_resp: flags=%b wdata=%h, required 0 0", flags, mem_wdata);
    end
  endtask

  task automatic test_rom_write();
    c_req = 1'b1; c_we = 1'b1; c_sel = 1'b0; c_addr = 32'h0000_0100; c_wdata = 32'h0000_1234;
    @(negedge clk);
    checks++;
    if (flags !== 7'b1000001 || mem_addr !== 32'h0000_0100) begin
      errors++;
      $display("FAIL rom_write_issue: flags=%b addr=%h, required 1000001 00000100", flags, mem_addr);
    end
    clear_inputs();
    @(negedge clk);
    checks++;
    if (flags !== 7'b0) begin
      errors++;
      $display("FAIL rom_write_resp: flags=%b, required 0", flags);
    end
  endtask

  task automatic test_back_to_back();
    logic          exp_l;
    logic [6:0]    exp_issue, exp_resp;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_rdata;
    test_reset();
    c_req = 1'b1; c_sel = 1'b1; c_addr = 32'h0000_0020;
    l_req = 1'b1; l_sel = 1'b1; l_addr = 32'h0000_0030;
    for (int i = 0; i < 4; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
      exp_l = (i % 2 == 1);
`else
      exp_l = 1'b0;
`endif
      exp_issue = {~exp_l, exp_l, 5'b00010};
      exp_resp  = {2'b00, ~exp_l, exp_l, 3'b000};
      exp_addr  = exp_l ? 32'h0000_0030 : 32'h0000_0020;
      exp_rdata = exp_l ? 32'h5A5A_5A6A : 32'h5A5A_5A7A;
      @(negedge clk);
      checks++;
      if (flags !== exp_issue || mem_addr !== exp_addr) begin
        errors++;
        $display("FAIL b2b_issue%0d: flags=%b addr=%h, required %b %h",
                 i, flags, mem_addr, exp_issue, exp_addr);
      end
      if (i == 3) begin
        c_req = 1'b0; l_req = 1'b0;
      end
      @(negedge clk);
      checks++;
      if (flags !== exp_resp || rdata !== exp_rdata) begin
        errors++;
        $display("FAIL b2b_resp%0d: flags=%b rdata=%h, required %b %h",
                 i, flags, rdata, exp_resp, exp_rdata);
      end
    end
    clear_inputs();
    @(negedge clk);
  endtask

  task automatic test_reset_in_resp();
    c_req = 1'b1; c_we = 1'b0; c_sel = 1'b1; c_addr = 32'h0000_0080;
    @(negedge clk);
    checks++;
    if (flags !== 7'b1000010) begin
      errors++;
      $display("FAIL rst_resp_issue: flags=%b, required 1000010", flags);
    end
    c_req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (flags !== 7'b0 || rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_resp_clear: flags=%b rdata=%h addr=%h, required all 0", flags, rdata, mem_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    c_req = 1'b1; c_addr = 32'h0000_0044;
    @(negedge clk);
    checks++;
    if (flags !== 7'b1000010 || mem_addr !== 32'h0000_0044) begin
      errors++;
      $display("FAIL rst_resp_regrant: flags=%b addr=%h, required 1000010 00000044", flags, mem_addr);
    end
    c_req = 1'b0;
    @(negedge clk);
    checks++;
    if (flags !== 7'b0010000 || rdata !== 32'h5A5A_5A1E) begin
      errors++;
      $display("FAIL rst_resp_reread: flags=%b rdata=%h, required 0010000 5a5a5a1e", flags, rdata);
    end
  endtask

  initial begin
    test_reset();
    test_core_read();
    test_loader_write();
    test_rom_write();
    test_back_to_back();
    test_reset_in_resp();
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_port_arbiter.md
MEMORY_PORT_ARBITER -- requirements
Module: memory_port_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the data width of all data buses.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the width of all address buses.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 c_req/c_we/c_sel  in  1 each  core request, write enable, memory select (0=ROM, 1=RAM).
REQ-006 c_addr  in  ADDR_WIDTH; c_wdata  in  DATA_WIDTH  core address and write data.
REQ-007 c_gnt  out  1; c_rvalid  out  1  core grant pulse and read-data-valid pulse.
REQ-008 l_req/l_we/l_sel  in  1 each; l_addr  in  ADDR_WIDTH; l_wdata  in  DATA_WIDTH  loader port, same meaning as the core port.
REQ-009 l_gnt  out  1; l_rvalid  out  1  loader grant and read-data-valid pulses.
REQ-010 rdata  out  DATA_WIDTH  shared read data; meaningful only while an rvalid is high.
REQ-011 mem_addr  out  ADDR_WIDTH; mem_wdata  out  DATA_WIDTH; mem_we  out  1; mem_sel  out  1  signals to the memory unit.
REQ-012 mem_q  in  DATA_WIDTH  memory read data, valid one clock after the address is presented.
REQ-013 rom_wr_err  out  1  one-cycle pulse when a write to ROM is attempted.

Function
REQ-014 FSM states SHALL be IDLE, ISSUE and RESP; the reset state is IDLE.
REQ-015 In IDLE and RESP, at the clock edge, if any request is high, a winner SHALL be chosen, its we/sel/addr/wdata latched, and the FSM SHALL move to ISSUE; otherwise it SHALL move to IDLE.
REQ-016 In ISSUE, mem_addr, mem_sel and mem_wdata SHALL be driven from the latched values, the winner's gnt SHALL be high for exactly that one cycle, and the FSM SHALL move to RESP unconditionally.
REQ-017 mem_we SHALL be high only in ISSUE, and only when latched we=1 and latched sel=1.
REQ-018 In RESP for a latched read, rdata SHALL equal mem_q combinationally and the owner's rvalid SHALL be high for one cycle; no rvalid SHALL be raised for a write.
REQ-019 Grant-to-rvalid latency SHALL be 1 cycle; back-to-back accesses SHALL sustain one access per 2 cycles (ISSUE, RESP, ISSUE...).
REQ-020 A requester SHALL hold req and its request fields stable until its gnt; req still high in the cycle after gnt is a new request.
REQ-021 Writes SHALL complete in ISSUE; the requester needs no further handshake.
REQ-022 A latched write with sel=0 SHALL keep mem_we=0 and pulse rom_wr_err in ISSUE; the grant SHALL still be issued.
REQ-023 Outside ISSUE, mem_addr, mem_wdata, mem_we and mem_sel SHALL be 0.
REQ-024 Only the owner's gnt and rvalid SHALL ever assert; c_gnt and l_gnt SHALL never be high together.

Reset
REQ-025 On reset, the FSM SHALL go to IDLE and all outputs and latched fields SHALL become 0, including during ISSUE/RESP; an in-flight access produces no rvalid.
REQ-026 On reset, the last-owner register SHALL be set to loader, so the core wins the first contention.

Configuration
REQ-027 With macro ARB_ROUND_ROBIN_EN defined, on simultaneous requests the grant SHALL go to the requester that is not the last owner; a single requester always wins.
REQ-028 Without ARB_ROUND_ROBIN_EN, the core SHALL always win simultaneous requests (fixed priority), and the last-owner register SHALL be omitted.

Verification
REQ-029 Core read, c_addr=0x10010004, sel=1 -> c_gnt in the next cycle, mem_addr=0x10010004, then c_rvalid=1 with rdata=mem_q.
REQ-030 Loader write, l_addr=0x00400000, sel=1, wdata=0xDEADBEEF -> l_gnt and mem_we=1 for one cycle, with mem_wdata=0xDEADBEEF; no l_rvalid.
REQ-031 Both requests held high for 4 accesses -> round robin gives C,L,C,L; fixed priority gives C,C,C,C with l_gnt never high.
REQ-032 Core write with sel=0 -> rom_wr_err=1 and c_gnt=1 in ISSUE; mem_we stays 0.
REQ-033 Reset asserted during RESP of a read -> no c_rvalid, all outputs 0 immediately; the next request is granted normally.
